// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: aluop codes, exception codes,
// LSU state encoding and small decode helpers.
package mem_lsu_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam logic ChipEnable  = 1'b1;
  localparam logic WriteEnable = 1'b1;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam int EXC_CODE_WIDTH = 5;
  localparam logic [EXC_CODE_WIDTH-1:0] EC_None = 5'd0;
  localparam logic [EXC_CODE_WIDTH-1:0] EC_AdEL = 5'd4;
  localparam logic [EXC_CODE_WIDTH-1:0] EC_AdES = 5'd5;
  localparam logic [EXC_CODE_WIDTH-1:0] EC_DBE  = 5'd7;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_WAIT = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  typedef struct packed {
    logic      mem;
    logic      we;
    lsu_size_t size;
    logic      sext;
  } lsu_dec_t;

  // Map an aluop onto access kind; anything unlisted is not a memory op.
  function automatic lsu_dec_t decode_aluop(input logic [7:0] op);
    lsu_dec_t d;
    d = '{mem: 1'b0, we: 1'b0, size: SZ_B, sext: 1'b0};
    case (op)
      EXE_LB_OP:  d = '{mem: 1'b1, we: 1'b0, size: SZ_B, sext: 1'b1};
      EXE_LBU_OP: d = '{mem: 1'b1, we: 1'b0, size: SZ_B, sext: 1'b0};
      EXE_LH_OP:  d = '{mem: 1'b1, we: 1'b0, size: SZ_H, sext: 1'b1};
      EXE_LHU_OP: d = '{mem: 1'b1, we: 1'b0, size: SZ_H, sext: 1'b0};
      EXE_LW_OP:  d = '{mem: 1'b1, we: 1'b0, size: SZ_W, sext: 1'b0};
      EXE_SB_OP:  d = '{mem: 1'b1, we: 1'b1, size: SZ_B, sext: 1'b0};
      EXE_SH_OP:  d = '{mem: 1'b1, we: 1'b1, size: SZ_H, sext: 1'b0};
      EXE_SW_OP:  d = '{mem: 1'b1, we: 1'b1, size: SZ_W, sext: 1'b0};
      default: ;
    endcase
    return d;
  endfunction

  // Byte accesses can never be misaligned.
  function automatic logic is_misaligned(input lsu_size_t size, input logic [1:0] low);
    logic m;
    case (size)
      SZ_H:    m = low[0];
      SZ_W:    m = (low != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lsu_lane_ctrl.sv
// Byte-lane steering for the LSU: byte enables, store-data replication and
// load-data extraction with sign/zero extension.
module mem_lsu_lane_ctrl
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int LANES = DATA_W / 8,
  localparam int OFF_W = $clog2(LANES)
) (
  input  lsu_size_t          size,
  input  logic               sext,
  input  logic [OFF_W-1:0]   offset,
  input  logic [31:0]        wdata,
  input  logic [DATA_W-1:0]  rdata,
  output logic [LANES-1:0]   sel,
  output logic [DATA_W-1:0]  wdata_rep,
  output logic [31:0]        rdata_ext
);

  logic [31:0] lane_word;

  // Shift the addressed lane down to bit 0, then size/extend it.
  always_comb begin
    sel       = '0;
    wdata_rep = '0;
    rdata_ext = '0;
    lane_word = 32'(rdata >> {offset, 3'b000});
    case (size)
      SZ_B: begin
        sel       = LANES'(1) << offset;
        wdata_rep = {(DATA_W / 8){wdata[7:0]}};
        rdata_ext = {{24{sext & lane_word[7]}}, lane_word[7:0]};
      end
      SZ_H: begin
        sel       = LANES'(3) << offset;
        wdata_rep = {(DATA_W / 16){wdata[15:0]}};
        rdata_ext = {{16{sext & lane_word[15]}}, lane_word[15:0]};
      end
      SZ_W: begin
        sel       = LANES'(15) << offset;
        wdata_rep = {(DATA_W / 32){wdata}};
        rdata_ext = lane_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Handshaked load/store unit: accepts one memory op, checks alignment, runs a
// single bus transfer with an ack timeout and returns one response pulse.
// Handshake: an op transfers on a cycle where req_valid_i & req_ready_o & ~flush_i;
// bus_req_o and all bus fields stay constant until the cycle bus_ack_i is seen.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter logic [31:0] PADDR_MASK = 32'h1FFF_FFFF,
  parameter int          TIMEOUT    = 256,
  parameter int          CNT_W      = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [7:0]                aluop_i,
  input  logic [31:0]               addr_i,
  input  logic [31:0]               wdata_i,
  input  logic [4:0]                wd_i,
  input  logic [31:0]               exc_epc_i,
  input  logic                      flush_i,
  output logic                      bus_req_o,
  output logic                      bus_we_o,
  output logic [DATA_W/8-1:0]       bus_sel_o,
  output logic [31:0]               bus_addr_o,
  output logic [DATA_W-1:0]         bus_wdata_o,
  input  logic                      bus_ack_i,
  input  logic [DATA_W-1:0]         bus_rdata_i,
  output logic                      rsp_valid_o,
  output logic [4:0]                wd_o,
  output logic                      wreg_o,
  output logic [31:0]               rdata_o,
  output logic [EXC_CODE_WIDTH-1:0] exc_code_o,
  output logic [31:0]               exc_epc_o,
  output logic [31:0]               exc_badvaddr_o,
  output logic                      stall_o,
  output lsu_state_t                lsu_state_o
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);

  lsu_state_t state_q, state_d;
  lsu_dec_t   dec;
  logic       misal, accept, timeout_hit, flushed_q;

  logic                      op_we, op_sext;
  lsu_size_t                 op_size;
  logic [31:0]               op_addr, op_wdata, op_epc, rdata_q;
  logic [4:0]                op_wd;
  logic [CNT_W-1:0]          cnt_q;
  logic [EXC_CODE_WIDTH-1:0] exc_q;

  logic [LANES-1:0]  lane_sel;
  logic [DATA_W-1:0] lane_wdata;
  logic [31:0]       lane_rdata, phys_addr;

  assign dec         = decode_aluop(aluop_i);
  assign misal       = is_misaligned(dec.size, addr_i[1:0]);
  assign accept      = (state_q == LSU_IDLE) && req_valid_i && dec.mem && !flush_i;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  mem_lsu_lane_ctrl #(.DATA_W(DATA_W)) u_lane (
    .size      (op_size),
    .sext      (op_sext),
    .offset    (op_addr[OFF_W-1:0]),
    .wdata     (op_wdata),
    .rdata     (bus_rdata_i),
    .sel       (lane_sel),
    .wdata_rep (lane_wdata),
    .rdata_ext (lane_rdata)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) state_q <= LSU_IDLE;
    else                  state_q <= state_d;
  end

  // Next state: a flushed transfer still completes on the bus but skips RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (accept) state_d = misal ? LSU_RESP : LSU_WAIT;
      LSU_WAIT: if (bus_ack_i || timeout_hit)
                  state_d = (flushed_q || flush_i) ? LSU_IDLE : LSU_RESP;
      LSU_RESP: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  // Op latch, wait counter, flush memory, exception code and load data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      op_we     <= 1'b0;
      op_sext   <= 1'b0;
      op_size   <= SZ_B;
      op_addr   <= '0;
      op_wdata  <= '0;
      op_wd     <= '0;
      op_epc    <= '0;
      exc_q     <= EC_None;
      rdata_q   <= '0;
      cnt_q     <= '0;
      flushed_q <= 1'b0;
    end else begin
      if (accept) begin
        op_we    <= dec.we;
        op_sext  <= dec.sext;
        op_size  <= dec.size;
        op_addr  <= addr_i;
        op_wdata <= wdata_i;
        op_wd    <= wd_i;
        op_epc   <= exc_epc_i;
        exc_q    <= misal ? (dec.we ? EC_AdES : EC_AdEL) : EC_None;
      end
      if (state_q == LSU_WAIT) begin
        cnt_q <= cnt_q + 1'b1;
        if (flush_i) flushed_q <= 1'b1;
        if (bus_ack_i)        rdata_q <= lane_rdata;
        else if (timeout_hit) exc_q   <= EC_DBE;
      end else begin
        cnt_q     <= '0;
        flushed_q <= 1'b0;
      end
    end
  end

  // Outputs: bus fields only while WAIT, response fields only during the RESP pulse.
  always_comb begin
    phys_addr              = op_addr & PADDR_MASK;
    phys_addr[OFF_W-1:0]   = '0;
    req_ready_o    = (state_q == LSU_IDLE) && (rst != RstEnable);
    bus_req_o      = (state_q == LSU_WAIT);
    bus_we_o       = 1'b0;
    bus_sel_o      = '0;
    bus_addr_o     = '0;
    bus_wdata_o    = '0;
    rsp_valid_o    = (state_q == LSU_RESP) && !flush_i;
    wd_o           = '0;
    wreg_o         = 1'b0;
    rdata_o        = '0;
    exc_code_o     = EC_None;
    exc_epc_o      = '0;
    exc_badvaddr_o = '0;
    if (bus_req_o) begin
      bus_we_o    = op_we ? WriteEnable : 1'b0;
      bus_sel_o   = lane_sel;
      bus_addr_o  = phys_addr;
      bus_wdata_o = op_we ? lane_wdata : '0;
    end
    if (rsp_valid_o) begin
      wd_o       = op_wd;
      exc_code_o = exc_q;
      wreg_o     = !op_we && (exc_q == EC_None);
      if (wreg_o) rdata_o = rdata_q;
      if (exc_q != EC_None) exc_epc_o = op_epc;
      if (exc_q == EC_AdEL || exc_q == EC_AdES) exc_badvaddr_o = op_addr;
    end
    stall_o     = (req_valid_i && !req_ready_o) || bus_req_o;
    lsu_state_o = state_q;
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: a 32-bit instance with a short timeout and a 64-bit
// instance with defaults, checked through per-scenario tasks and response
// scoreboards.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int RW = 107;

  logic clk, rst;

  // 32-bit instance signals
  logic        req_valid, req_ready, flush, bus_req, bus_we, bus_ack, rsp_valid, wreg, stall;
  logic [7:0]  aluop;
  logic [31:0] addr, wdata, epc, bus_addr, bus_wdata, bus_rdata, rdata, exc_epc, badvaddr;
  logic [4:0]  wd, wd_out, exc_code;
  logic [3:0]  bus_sel;
  lsu_state_t  state_a;

  // 64-bit instance signals
  logic        b_req_valid, b_req_ready, b_flush, b_bus_req, b_bus_we, b_bus_ack, b_rsp_valid, b_wreg, b_stall;
  logic [7:0]  b_aluop;
  logic [31:0] b_addr, b_wdata, b_epc, b_bus_addr, b_rdata, b_exc_epc, b_badvaddr;
  logic [63:0] b_bus_wdata, b_bus_rdata;
  logic [4:0]  b_wd, b_wd_out, b_exc_code;
  logic [7:0]  b_bus_sel;
  lsu_state_t  state_b;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] exp64_q[$];
  logic [RW-1:0] obs_a, exp_a, obs_b, exp_b;
  int errors = 0;
  int checks = 0;

  mem_lsu #(.DATA_W(32), .TIMEOUT(4), .CNT_W(9)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .aluop_i(aluop), .addr_i(addr), .wdata_i(wdata), .wd_i(wd), .exc_epc_i(epc),
    .flush_i(flush), .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_sel_o(bus_sel),
    .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_ack_i(bus_ack),
    .bus_rdata_i(bus_rdata), .rsp_valid_o(rsp_valid), .wd_o(wd_out), .wreg_o(wreg),
    .rdata_o(rdata), .exc_code_o(exc_code), .exc_epc_o(exc_epc),
    .exc_badvaddr_o(badvaddr), .stall_o(stall), .lsu_state_o(state_a)
  );

  mem_lsu #(.DATA_W(64)) dut64 (
    .clk(clk), .rst(rst), .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
    .aluop_i(b_aluop), .addr_i(b_addr), .wdata_i(b_wdata), .wd_i(b_wd), .exc_epc_i(b_epc),
    .flush_i(b_flush), .bus_req_o(b_bus_req), .bus_we_o(b_bus_we), .bus_sel_o(b_bus_sel),
    .bus_addr_o(b_bus_addr), .bus_wdata_o(b_bus_wdata), .bus_ack_i(b_bus_ack),
    .bus_rdata_i(b_bus_rdata), .rsp_valid_o(b_rsp_valid), .wd_o(b_wd_out), .wreg_o(b_wreg),
    .rdata_o(b_rdata), .exc_code_o(b_exc_code), .exc_epc_o(b_exc_epc),
    .exc_badvaddr_o(b_badvaddr), .stall_o(b_stall), .lsu_state_o(state_b)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] pack_rsp(input logic w, input logic [4:0] d, input logic [31:0] r,
                                             input logic [4:0] ec, input logic [31:0] pc, input logic [31:0] bv);
    return {w, d, r, ec, pc, bv};
  endfunction

  // Scoreboards: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      obs_a = pack_rsp(wreg, wd_out, rdata, exc_code, exc_epc, badvaddr);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp32_unexpected: got %h, required no response", obs_a);
      end else begin
        exp_a = exp_q.pop_front();
        if (obs_a !== exp_a) begin
          errors++;
          $display("FAIL rsp32: got %h, required %h", obs_a, exp_a);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_rsp_valid === 1'b1) begin
      obs_b = pack_rsp(b_wreg, b_wd_out, b_rdata, b_exc_code, b_exc_epc, b_badvaddr);
      checks++;
      if (exp64_q.size() == 0) begin
        errors++;
        $display("FAIL rsp64_unexpected: got %h, required no response", obs_b);
      end else begin
        exp_b = exp64_q.pop_front();
        if (obs_b !== exp_b) begin
          errors++;
          $display("FAIL rsp64: got %h, required %h", obs_b, exp_b);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue32(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] r, input logic [31:0] pc);
    aluop = op; addr = a; wdata = d; wd = r; epc = pc; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; aluop = 8'h00;
  endtask

  task automatic issue64(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] r, input logic [31:0] pc);
    b_aluop = op; b_addr = a; b_wdata = d; b_wd = r; b_epc = pc; b_req_valid = 1'b1;
    tick();
    b_req_valid = 1'b0; b_aluop = 8'h00;
  endtask

  task automatic wait_drain(input bit wide, input string name);
    int left;
    left = wide ? exp64_q.size() : exp_q.size();
    for (int i = 0; i < 20 && left != 0; i++) begin
      tick();
      left = wide ? exp64_q.size() : exp_q.size();
    end
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d responses still pending, required 0", name, left);
    end
    tick();
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if ({req_ready, bus_req, rsp_valid, stall, wreg, exc_code, bus_sel} !== '0 || state_a !== LSU_IDLE) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b req=%b rsp=%b stall=%b ec=%h sel=%b state=%0d, required all 0",
               req_ready, bus_req, rsp_valid, stall, exc_code, bus_sel, state_a);
    end
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b/%b, required 1/1", req_ready, b_req_ready);
    end
  endtask

  task automatic test_lb_sign();
    exp_q.push_back(pack_rsp(1'b1, 5'd3, 32'hFFFF_FF80, EC_None, 32'h0, 32'h0));
    issue32(EXE_LB_OP, 32'h8000_0003, 32'h0, 5'd3, 32'h100);
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h0 || bus_sel !== 4'b1000 || bus_we !== 1'b0 || stall !== 1'b1) begin
      errors++;
      $display("FAIL lb_bus: req=%b addr=%h sel=%b we=%b stall=%b, required 1 00000000 1000 0 1",
               bus_req, bus_addr, bus_sel, bus_we, stall);
    end
    tick(); tick();
    checks++;
    if (bus_req !== 1'b1 || bus_sel !== 4'b1000) begin
      errors++;
      $display("FAIL lb_bus_hold: req=%b sel=%b, required 1 1000", bus_req, bus_sel);
    end
    bus_ack = 1'b1; bus_rdata = 32'h8012_3456;
    tick();
    bus_ack = 1'b0;
    wait_drain(1'b0, "lb");
  endtask

  task automatic test_sh_store();
    exp_q.push_back(pack_rsp(1'b0, 5'd4, 32'h0, EC_None, 32'h0, 32'h0));
    issue32(EXE_SH_OP, 32'h0000_0102, 32'hDEAD_1234, 5'd4, 32'h104);
    checks++;
    if (bus_sel !== 4'b1100 || bus_wdata !== 32'h1234_1234 || bus_we !== 1'b1 || bus_addr !== 32'h100) begin
      errors++;
      $display("FAIL sh_bus: sel=%b wdata=%h we=%b addr=%h, required 1100 12341234 1 00000100",
               bus_sel, bus_wdata, bus_we, bus_addr);
    end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL sh_latency: rsp_valid=%b two cycles after accept, required 1", rsp_valid);
    end
    wait_drain(1'b0, "sh");
  endtask

  task automatic test_misaligned();
    exp_q.push_back(pack_rsp(1'b0, 5'd7, 32'h0, EC_AdEL, 32'h200, 32'h6));
    issue32(EXE_LW_OP, 32'h0000_0006, 32'h0, 5'd7, 32'h200);
    checks++;
    if (bus_req !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL lw_misaligned: req=%b rsp=%b, required 0 1", bus_req, rsp_valid);
    end
    wait_drain(1'b0, "adel");
    exp_q.push_back(pack_rsp(1'b0, 5'd8, 32'h0, EC_AdES, 32'h204, 32'h6));
    issue32(EXE_SW_OP, 32'h0000_0006, 32'h5555_AAAA, 5'd8, 32'h204);
    checks++;
    if (bus_req !== 1'b0 || bus_we !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL sw_misaligned: req=%b we=%b rsp=%b, required 0 0 1", bus_req, bus_we, rsp_valid);
    end
    wait_drain(1'b0, "ades");
  endtask

  task automatic test_non_mem();
    issue32(8'h21, 32'h0000_0010, 32'h0, 5'd9, 32'h208);
    checks++;
    if (req_ready !== 1'b1 || bus_req !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL non_mem: ready=%b req=%b rsp=%b, required 1 0 0", req_ready, bus_req, rsp_valid);
    end
    tick();
  endtask

  task automatic test_timeout();
    int hi;
    hi = 0;
    exp_q.push_back(pack_rsp(1'b0, 5'd9, 32'h0, EC_DBE, 32'h300, 32'h0));
    issue32(EXE_LW_OP, 32'h0000_0010, 32'h0, 5'd9, 32'h300);
    for (int i = 0; i < 4; i++) begin
      if (bus_req === 1'b1 && stall === 1'b1) hi++;
      tick();
    end
    checks++;
    if (hi != 4) begin
      errors++;
      $display("FAIL timeout_req_cycles: req&stall high %0d cycles, required 4", hi);
    end
    checks++;
    if (bus_req !== 1'b0 || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL timeout_drop: req=%b rsp=%b, required 0 1", bus_req, rsp_valid);
    end
    wait_drain(1'b0, "dbe");
  endtask

  task automatic test_ack_wins();
    exp_q.push_back(pack_rsp(1'b1, 5'd10, 32'hCAFE_F00D, EC_None, 32'h0, 32'h0));
    issue32(EXE_LW_OP, 32'h0000_0044, 32'h0, 5'd10, 32'h304);
    tick(); tick(); tick();
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    tick();
    bus_ack = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL ack_at_timeout: rsp=%b, required 1", rsp_valid);
    end
    wait_drain(1'b0, "ack_wins");
  endtask

  task automatic test_flush();
    // flush while waiting: transfer completes, no response
    issue32(EXE_LW_OP, 32'h0000_0020, 32'h0, 5'd11, 32'h400);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (bus_req !== 1'b1) begin
      errors++;
      $display("FAIL flush_wait_hold: req=%b, required 1", bus_req);
    end
    tick();
    bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
    tick();
    bus_ack = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_wait_end: rsp=%b ready=%b req=%b, required 0 1 0", rsp_valid, req_ready, bus_req);
    end
    tick();
    // flush in RESP suppresses the pulse
    issue32(EXE_LH_OP, 32'h0000_0005, 32'h0, 5'd12, 32'h404);
    flush = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_resp: rsp=%b, required 0", rsp_valid);
    end
    tick();
    flush = 1'b0;
    // flush in IDLE blocks acceptance
    flush = 1'b1;
    issue32(EXE_LW_OP, 32'h0000_0050, 32'h0, 5'd13, 32'h408);
    flush = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || bus_req !== 1'b0 || state_a !== LSU_IDLE) begin
      errors++;
      $display("FAIL flush_idle: ready=%b req=%b state=%0d, required 1 0 0", req_ready, bus_req, state_a);
    end
    // stray ack while idle
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL ack_idle: ready=%b rsp=%b, required 1 0", req_ready, rsp_valid);
    end
    tick();
  endtask

  task automatic test_async_reset();
    issue32(EXE_LW_OP, 32'h0000_0060, 32'h0, 5'd14, 32'h500);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus_req, bus_we, bus_sel, bus_addr, req_ready, rsp_valid, stall} !== '0 || state_a !== LSU_IDLE) begin
      errors++;
      $display("FAIL async_reset: req=%b sel=%b addr=%h ready=%b rsp=%b stall=%b state=%0d, required all 0",
               bus_req, bus_sel, bus_addr, req_ready, rsp_valid, stall, state_a);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_release: ready=%b, required 1", req_ready);
    end
    tick();
  endtask

  task automatic test_lanes64();
    exp64_q.push_back(pack_rsp(1'b1, 5'd11, 32'h0000_BEEF, EC_None, 32'h0, 32'h0));
    issue64(EXE_LHU_OP, 32'h0000_1006, 32'h0, 5'd11, 32'h600);
    checks++;
    if (b_bus_sel !== 8'hC0 || b_bus_addr !== 32'h0000_1000 || b_bus_req !== 1'b1) begin
      errors++;
      $display("FAIL lhu64_bus: sel=%h addr=%h req=%b, required c0 00001000 1", b_bus_sel, b_bus_addr, b_bus_req);
    end
    b_bus_ack = 1'b1; b_bus_rdata = 64'hBEEF_8000_1111_2222;
    tick();
    b_bus_ack = 1'b0;
    wait_drain(1'b1, "lhu64");
    exp64_q.push_back(pack_rsp(1'b0, 5'd12, 32'h0, EC_None, 32'h0, 32'h0));
    issue64(EXE_SB_OP, 32'h0000_0025, 32'h1234_56AB, 5'd12, 32'h604);
    checks++;
    if (b_bus_sel !== 8'h20 || b_bus_wdata !== 64'hABAB_ABAB_ABAB_ABAB || b_bus_addr !== 32'h20 || b_bus_we !== 1'b1) begin
      errors++;
      $display("FAIL sb64_bus: sel=%h wdata=%h addr=%h we=%b, required 20 abababababababab 00000020 1",
               b_bus_sel, b_bus_wdata, b_bus_addr, b_bus_we);
    end
    b_bus_ack = 1'b1;
    tick();
    b_bus_ack = 1'b0;
    wait_drain(1'b1, "sb64");
  endtask

  initial begin
    req_valid = 1'b0; aluop = '0; addr = '0; wdata = '0; wd = '0; epc = '0;
    flush = 1'b0; bus_ack = 1'b0; bus_rdata = 32'($urandom_range(0, 32'hFFFF));
    b_req_valid = 1'b0; b_aluop = '0; b_addr = '0; b_wdata = '0; b_wd = '0; b_epc = '0;
    b_flush = 1'b0; b_bus_ack = 1'b0; b_bus_rdata = '0;
    test_reset();
    test_lb_sign();
    test_sh_store();
    test_misaligned();
    test_non_mem();
    test_timeout();
    test_ack_wins();
    test_flush();
    test_async_reset();
    test_lanes64();
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Parametrised load/store unit that replaces the purely combinational memory stage with a handshaked, multi-cycle data-bus master. It accepts one memory op from EX/MEM, checks alignment, drives byte-lane bus requests of configurable width and waits for a variable-latency ack with timeout. It returns extended load data or an exception record to the writeback path, and stalls the pipeline while busy.

Parameters:
DATA_W, 32, bus data width; 32 or 64; lanes = DATA_W/8.
PADDR_MASK, 32'h1FFF_FFFF, AND-mask converting virtual to physical bus address.
TIMEOUT, 256, cycles in WAIT without ack before bus error; 0 disables the timeout.
CNT_W, 9, width of the timeout counter; must hold TIMEOUT.

Ports:
clk  in  1  clock.
rst  in  1  reset; asynchronous, active-high.
req_valid_i  in  1  memory op present.
req_ready_o  out  1  unit can accept (state IDLE).
aluop_i  in  8  LB/LBU/LH/LHU/LW/SB/SH/SW codes from defines; others are not memory ops.
addr_i  in  32  unaligned virtual address.
wdata_i  in  32  store data (reg2).
wd_i  in  5  destination register.
exc_epc_i  in  32  PC of the op.
flush_i  in  1  exception/eret flush from CP0.
bus_req_o  out  1  bus request, held until ack.
bus_we_o  out  1  write.
bus_sel_o  out  DATA_W/8  byte enables.
bus_addr_o  out  32  physical address, lane bits zeroed.
bus_wdata_o  out  DATA_W  store data replicated onto lanes.
bus_ack_i  in  1  access done; rdata valid on loads.
bus_rdata_i  in  DATA_W  read data.
rsp_valid_o  out  1  one-cycle result pulse.
wd_o  out  5  destination register.
wreg_o  out  1  writeback enable (load with no exception).
rdata_o  out  32  extended load result.
exc_code_o  out  EXC_CODE_WIDTH  EC_None/EC_AdEL/EC_AdES/EC_DBE.
exc_epc_o  out  32  exc_epc_i of the op when excepting, else 0.
exc_badvaddr_o  out  32  addr_i when AdEL/AdES, else 0.
stall_o  out  1  = req_valid_i & ~req_ready_o, or state WAIT.

Behaviour:
- Reset (async): state IDLE, every output 0, exc_code_o = EC_None, counter 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE: on req_valid_i with a memory op, latch the op.
  - Misaligned (H with addr[0]=1; W with addr[1:0]!=0): go to RESP with AdEL (loads) or AdES (stores); bus is not touched.
  - Aligned: assert bus_req_o the next cycle and go to WAIT.
  - Byte ops never fault.
- IDLE, non-memory aluop_i: ignored, no response.
- Lane offset = addr[log2(DATA_W/8)-1:0].
- bus_sel_o: B = one bit, H = two bits, W = four bits, shifted by the offset.
- bus_wdata_o: byte replicated DATA_W/8 times, half replicated DATA_W/16 times, word replicated DATA_W/32 times.
- bus_addr_o = addr & PADDR_MASK with the lane bits cleared.
- WAIT: all bus outputs stable until bus_ack_i; the counter increments each cycle.
  - Ack: register the extracted data, go to RESP.
  - Counter == TIMEOUT-1 with no ack (TIMEOUT>0): drop bus_req_o, go to RESP with EC_DBE, exc_badvaddr_o = 0.
- RESP: rsp_valid_o = 1 for exactly one cycle, then IDLE. req_ready_o = 1 only in IDLE.
- Latencies:
  - Ack in the first WAIT cycle gives rsp_valid_o 2 cycles after acceptance.
  - Misaligned ops give rsp_valid_o 1 cycle after acceptance.
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the selected 32-bit word.
- flush_i:
  - In IDLE: blocks acceptance.
  - In RESP: suppresses rsp_valid_o.
  - In WAIT: bus_req_o holds until ack or timeout (bus transfers are never aborted), then returns to IDLE with no response pulse.
- Ack arriving in the same cycle as timeout expiry: ack wins.
- bus_ack_i outside WAIT is ignored.

Decomposition:
- Shared package: aluop codes, EC_* codes, EXC_CODE_WIDTH, RstEnable, ChipEnable/WriteEnable (already in defines.v).
- Add EC_DBE (7) and a LSU state encoding to that package.
- Sub-module: lsu_lane_ctrl, combinational. Inputs: size, signedness, offset, store data, read data. Outputs: sel, replicated wdata, extracted/extended rdata. Parametrised by DATA_W.

Test Plan:
- DATA_W=32, LB at 0x8000_0003, ack after 3 cycles with rdata 0x80xx_xxxx → bus_addr_o 0x0000_0000, bus_sel_o 4'b1000; rsp rdata_o 0xFFFF_FF80, wreg_o 1.
- SH 0x1234 at 0x0000_0102, immediate ack → bus_sel_o 4'b1100, bus_wdata_o 0x1234_1234, rsp with EC_None, wreg_o 0.
- LW at 0x0000_0006 → no bus_req_o; rsp 1 cycle later, EC_AdEL, exc_badvaddr_o 0x0000_0006; SW at the same address → EC_AdES.
- DATA_W=64, LHU at offset 6, rdata[63:48]=0xBEEF → bus_sel_o 8'hC0, rdata_o 0x0000_BEEF.
- TIMEOUT=4, no ack → bus_req_o high 4 cycles then low; rsp EC_DBE; stall_o high throughout.
- flush_i in WAIT, ack 2 cycles later → no rsp_valid_o pulse, req_ready_o high the cycle after ack. Async rst mid-WAIT → all outputs 0 immediately.
